// File: rtl/register_dump_reader.sv
// Debug-side register dump engine: stalls the CPU, drains writebacks, then streams
// every register-file entry out over a valid/ready handshake.
module register_dump_reader #(
  parameter int NR_OF_REGS   = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        cpuClock,
  input  logic        reset,
  input  logic        dumpRequest,
  input  logic        dumpAbort,
  output logic        stallCpu,
  output logic [4:0]  readAddr,
  input  logic [31:0] readData,
  output logic [31:0] dataOut,
  output logic [4:0]  dataIndex,
  output logic        dataValid,
  input  logic        dataReady,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [4:0] LAST_INDEX = 5'(NR_OF_REGS - 1);
  localparam bit         HAS_DRAIN  = (DRAIN_CYCLES > 0);
  localparam logic [3:0] DRAIN_INIT = HAS_DRAIN ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  logic [2:0]  r_state;
  logic [4:0]  r_index;
  logic [3:0]  r_drain_cnt;
  logic [31:0] r_data_out;
  logic [4:0]  r_data_index;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  logic [2:0]  w_next_state;
  logic [4:0]  w_next_index;
  logic [3:0]  w_next_drain;
  logic        w_capture;
  logic        w_clear_valid;
  logic        w_next_busy;

  // Next-state logic; abort beats a same-cycle handshake in WAIT.
  always_comb begin
    w_next_state  = r_state;
    w_next_index  = r_index;
    w_next_drain  = r_drain_cnt;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dumpRequest) begin
          w_next_index = 5'd0;
          if (HAS_DRAIN) begin
            w_next_state = ST_DRAIN;
            w_next_drain = DRAIN_INIT;
          end else begin
            w_next_state = ST_READ;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (dumpAbort) begin
          w_next_state  = ST_IDLE;
          w_next_index  = 5'd0;
          w_clear_valid = 1'b1;
        end else if (r_drain_cnt == 4'd0) begin
          w_next_state = ST_READ;
        end else begin
          w_next_drain = r_drain_cnt - 4'd1;
        end
      end
      ST_READ: begin
        if (dumpAbort) begin
          w_next_state  = ST_IDLE;
          w_next_index  = 5'd0;
          w_clear_valid = 1'b1;
        end else begin
          w_capture    = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dumpAbort) begin
          w_next_state  = ST_IDLE;
          w_next_index  = 5'd0;
          w_clear_valid = 1'b1;
        end else if (r_valid && dataReady) begin
          w_clear_valid = 1'b1;
          if (r_index == LAST_INDEX) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_index = r_index + 5'd1;
            w_next_state = ST_READ;
          end
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        w_next_index = 5'd0;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state  = ST_IDLE;
        w_next_index  = 5'd0;
        w_next_drain  = 4'd0;
        w_clear_valid = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_next_busy = (w_next_state == ST_DRAIN) || (w_next_state == ST_READ) ||
                  (w_next_state == ST_WAIT);
  end

  always_ff @(posedge cpuClock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_index      <= 5'd0;
      r_drain_cnt  <= 4'd0;
      r_data_out   <= 32'd0;
      r_data_index <= 5'd0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_index     <= w_next_index;
      r_drain_cnt <= w_next_drain;
      r_busy      <= w_next_busy;
      r_done      <= (w_next_state == ST_DONE);
      if (w_capture) begin
        r_data_out   <= readData;
        r_data_index <= r_index;
        r_valid      <= 1'b1;
      end else if (w_clear_valid) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign stallCpu  = r_busy;
  assign busy      = r_busy;
  assign done      = r_done;
  assign readAddr  = r_index;
  assign dataOut   = r_data_out;
  assign dataIndex = r_data_index;
  assign dataValid = r_valid;

endmodule
